fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point multiplier. Successor to the single-cycle FP32 multiplier.
//  Adds exponent normalisation, round-to-nearest-even, special-value handling, exception flags and valid/ready flow control.
//  Sits in the FP arithmetic unit beside the adder; its result feeds the unit's output mux.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W  23  stored fraction width (hidden bit implicit); FP32 by default, 5/10 gives FP16
// PORTS
//  clk        in   1              clock; all logic on rising edge
//  rst        in   1              reset; synchronous, active-high
//  in_valid   in   1              operand pair valid
//  in_ready   out  1              block accepts operands this cycle
//  num1       in   1+EXP_W+MAN_W  operand A {sign, exp, frac}
//  num2       in   1+EXP_W+MAN_W  operand B
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts result
//  S          out  1+EXP_W+MAN_W  product
//  flags      out  4              {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset: all stage valids = 0; S = 0; flags = 0; out_valid = 0. in_ready = 1 after reset.
//  - Reset mid-operation: all in-flight results are discarded with no output.
//  - 3 stages; latency is 3 cycles from accept to out_valid when never stalled. Throughput is 1 per cycle.
//  - Handshake:
//    - Global advance en = !out_valid | out_ready; in_ready = en (combinational).
//    - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//    - While stalled, S/flags/out_valid are held stable; no result is dropped or duplicated; order is preserved.
//    - Bubbles propagate as valid = 0; they do not collapse.
//  - S1 (unpack/classify/multiply):
//    - sign = s1 ^ s2.
//    - exp = 0 means zero: denormals are flushed to zero, sign kept.
//    - exp = all-ones means inf (frac = 0) or NaN (frac != 0).
//    - Mantissas {1,frac} are multiplied into a 2*(MAN_W+1)-bit product.
//    - Biased exponent e = e1 + e2 - bias, computed in EXP_W+2 bits signed (no wrap).
//  - S2 (normalise):
//    - If the product MSB is set: shift right by 1 and e += 1.
//    - Extract MAN_W fraction bits plus guard; sticky = OR of all remaining lower bits.
//  - S3 (round/pack):
//    - Round to nearest even: round up iff guard & (sticky | lsb).
//    - Mantissa carry-out: fraction = 0 and e += 1.
//    - inexact = guard | sticky.
//    - e >= all-ones: result is +/-inf; overflow = 1, inexact = 1.
//    - e <= 0: result is signed zero (no subnormal output); underflow = 1, inexact = 1.
//  - Special-case priority (resolved in S1, carried as a class tag, bypasses rounding; only invalid may be set):
//    1. Either operand NaN, or zero*inf: canonical qNaN {0, all-ones, 1 followed by 0s}. invalid = 1.
//    2. Else either operand inf: inf with xor sign. No flags.
//    3. Else either operand zero: zero with xor sign. No flags.
//  - flags are per-result and travel with S; they are not sticky across results.
// STRUCTURE
//  - fp_pkg (shared with the adder): fp_class_e {ZERO, NORM, INF, NAN}, fp_flags_t struct, bias/QNAN constants as functions of EXP_W/MAN_W.
//  - One sub-module, fp_round_pack: S3 logic, combinational; inputs sign, e, fraction, guard, sticky, class; outputs S, flags.
//  - Multiplier is the inferred '*' operator (DSP mapping). Pipeline registers live in fp_mul_pipe.
// TESTING (FP32 unless noted; out_ready=1 unless noted)
//  1. 0x40400000 * 0x40200000 (3.0*2.5)     -> S=0x40F00000, flags=0, out_valid exactly 3 cycles after accept
//  2. 0x3FC00000 * 0x3FC00000 (1.5*1.5)     -> S=0x40100000 (normalise shift), flags=0
//     0x3F800001 * 0x3F800001               -> S=0x3F800002, inexact=1 (RNE)
//  3. 0x00000000 * 0x7F800000 (0*inf)       -> S=0x7FC00000, invalid=1
//     0x80000000 * 0x3F800000               -> S=0x80000000, flags=0
//  4. 0x7F7FFFFF * 0x40000000               -> S=0x7F800000, overflow=1, inexact=1
//     0x00800000 * 0x3F000000               -> S=0x00000000, underflow=1, inexact=1
//  5. Stream 5 back-to-back pairs; out_ready=0 for cycles 4-8 -> in_ready falls once pipe full,
//     S held stable while stalled, all 5 results in order, none lost or duplicated.
//     Then assert rst with 2 in flight -> no out_valid afterwards, outputs 0.
//  6. EXP_W=5, MAN_W=10: 0x3E00 * 0x4000 (1.5*2.0) -> S=0x4200, flags=0

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FP arithmetic unit (multiplier and adder).
// Format constants are derived from the exponent/fraction widths of each instance.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to their width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final multiplier stage: round-to-nearest-even, exponent range check and packing.
// Special classes bypass rounding entirely; only NaN raises a flag on that path.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     i_sign,
  input  logic signed [EXP_W+1:0]  i_exp,
  input  logic [MAN_W-1:0]         i_frac,
  input  logic                     i_guard,
  input  logic                     i_sticky,
  input  logic [1:0]               i_class,
  output logic [EXP_W+MAN_W:0]     o_s,
  output logic [3:0]               o_flags
);

  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [FW-1:0]        QNAN     = FW'(fp_qnan(EXP_W, MAN_W));

  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  function automatic logic [FW-1:0] sat_inf(input logic sign);
    return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [FW-1:0] sat_zero(input logic sign);
    return {sign, {(FW-1){1'b0}}};
  endfunction

  logic [MAN_W:0]        w_mant;
  logic signed [EW-1:0]  w_exp;
  fp_flags_t             w_flags;

  always_comb begin
    w_flags = '0;
    o_s     = '0;
    // A carry out of the fraction leaves the low bits zero and bumps the exponent.
    w_mant  = {1'b0, i_frac} + (MAN_W+1)'(rne_up(i_frac[0], i_guard, i_sticky));
    w_exp   = i_exp + $signed(EW'(w_mant[MAN_W]));
    case (fp_class_e'(i_class))
      NAN: begin
        o_s             = QNAN;
        w_flags.invalid = 1'b1;
      end
      INF:  o_s = sat_inf(i_sign);
      ZERO: o_s = sat_zero(i_sign);
      default: begin
        if (w_exp >= EXP_MAX) begin
          o_s              = sat_inf(i_sign);
          w_flags.overflow = 1'b1;
          w_flags.inexact  = 1'b1;
        end else if (w_exp <= EXP_ZERO) begin
          o_s               = sat_zero(i_sign);
          w_flags.underflow = 1'b1;
          w_flags.inexact   = 1'b1;
        end else begin
          o_s             = {i_sign, w_exp[EXP_W-1:0], w_mant[MAN_W-1:0]};
          w_flags.inexact = i_guard | i_sticky;
        end
      end
    endcase
    o_flags = w_flags;
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Stages: unpack/classify/multiply, normalise, round/pack; one global advance enable.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] num1,
  input  logic [EXP_W+MAN_W:0] num2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] S,
  output logic [3:0]           flags
);

  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

  logic w_en;
  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en;

  logic [EXP_W-1:0]     w_ea_p0, w_eb_p0;
  logic [MAN_W-1:0]     w_fa_p0, w_fb_p0;
  logic                 w_za_p0, w_zb_p0, w_ia_p0, w_ib_p0, w_na_p0, w_nb_p0;
  logic [PW-1:0]        w_ma_p0, w_mb_p0, w_prod_p0;
  logic signed [EW-1:0] w_exp_p0;
  fp_class_e            w_cls_p0;

  assign w_ea_p0 = num1[FW-2 -: EXP_W];
  assign w_eb_p0 = num2[FW-2 -: EXP_W];
  assign w_fa_p0 = num1[MAN_W-1:0];
  assign w_fb_p0 = num2[MAN_W-1:0];

  // Zero exponent covers denormals too: they are flushed to signed zero.
  assign w_za_p0 = ~|w_ea_p0;
  assign w_zb_p0 = ~|w_eb_p0;
  assign w_ia_p0 = (&w_ea_p0) & ~|w_fa_p0;
  assign w_ib_p0 = (&w_eb_p0) & ~|w_fb_p0;
  assign w_na_p0 = (&w_ea_p0) & |w_fa_p0;
  assign w_nb_p0 = (&w_eb_p0) & |w_fb_p0;

  always_comb begin
    if (w_na_p0 | w_nb_p0 | (w_za_p0 & w_ib_p0) | (w_ia_p0 & w_zb_p0)) w_cls_p0 = NAN;
    else if (w_ia_p0 | w_ib_p0)                                        w_cls_p0 = INF;
    else if (w_za_p0 | w_zb_p0)                                        w_cls_p0 = ZERO;
    else                                                               w_cls_p0 = NORM;
  end

  assign w_ma_p0   = PW'({1'b1, w_fa_p0});
  assign w_mb_p0   = PW'({1'b1, w_fb_p0});
  assign w_prod_p0 = w_ma_p0 * w_mb_p0;
  assign w_exp_p0  = $signed(EW'(w_ea_p0)) + $signed(EW'(w_eb_p0)) - BIAS;

  // ---- stage 1 register boundary ----
  logic                 r_vld_p1;
  logic                 r_sign_p1;
  fp_class_e            r_cls_p1;
  logic signed [EW-1:0] r_exp_p1;
  logic [PW-1:0]        r_prod_p1;

  always_ff @(posedge clk) begin
    if (rst)       r_vld_p1 <= 1'b0;
    else if (w_en) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_sign_p1 <= num1[FW-1] ^ num2[FW-1];
      r_cls_p1  <= w_cls_p0;
      r_exp_p1  <= w_exp_p0;
      r_prod_p1 <= w_prod_p0;
    end
  end

  // Product of two [1,2) mantissas lies in [1,4); align the leading one to the top bit.
  logic                 w_msb_p1;
  logic [PW-2:0]        w_norm_p1;
  logic signed [EW-1:0] w_exp_p1;

  assign w_msb_p1  = r_prod_p1[PW-1];
  assign w_norm_p1 = w_msb_p1 ? r_prod_p1[PW-2:0] : {r_prod_p1[PW-3:0], 1'b0};
  assign w_exp_p1  = r_exp_p1 + $signed(EW'(w_msb_p1));

  // ---- stage 2 register boundary ----
  logic                 r_vld_p2;
  logic                 r_sign_p2;
  fp_class_e            r_cls_p2;
  logic signed [EW-1:0] r_exp_p2;
  logic [MAN_W-1:0]     r_frac_p2;
  logic                 r_guard_p2;
  logic                 r_sticky_p2;

  always_ff @(posedge clk) begin
    if (rst)       r_vld_p2 <= 1'b0;
    else if (w_en) r_vld_p2 <= r_vld_p1;
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_sign_p2   <= r_sign_p1;
      r_cls_p2    <= r_cls_p1;
      r_exp_p2    <= w_exp_p1;
      r_frac_p2   <= w_norm_p1[PW-2 -: MAN_W];
      r_guard_p2  <= w_norm_p1[PW-2-MAN_W];
      r_sticky_p2 <= |w_norm_p1[PW-3-MAN_W:0];
    end
  end

  logic [FW-1:0] w_s_p2;
  logic [3:0]    w_flags_p2;

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_sign   (r_sign_p2),
    .i_exp    (r_exp_p2),
    .i_frac   (r_frac_p2),
    .i_guard  (r_guard_p2),
    .i_sticky (r_sticky_p2),
    .i_class  (r_cls_p2),
    .o_s      (w_s_p2),
    .o_flags  (w_flags_p2)
  );

  // ---- stage 3 (output) register boundary ----
  // Result and flags load only with a valid result, so bubbles leave the last value in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      S         <= '0;
      flags     <= '0;
    end else if (w_en) begin
      out_valid <= r_vld_p2;
      if (r_vld_p2) begin
        S     <= w_s_p2;
        flags <= w_flags_p2;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: FP32 instance plus an FP16 instance.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] num1, num2, S;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_num1, h_num2, h_S;
  logic [3:0]  h_flags;

  int errors = 0;
  int checks = 0;

  logic [35:0] sb[$];
  logic [19:0] sb16[$];

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .num1(h_num1), .num2(h_num2), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .S(h_S), .flags(h_flags)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num1 = '0; num2 = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_num1 = '0; h_num2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (S !== 32'h0) begin errors++; $display("FAIL reset_S: got %h want 00000000", S); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1; h_out_ready = 1'b1;
  endtask

  task automatic test_latency();
    logic [35:0] e;
    int lat;
    bit got;
    @(posedge clk); #1;
    num1 = 32'h40400000; num2 = 32'h40200000; in_valid = 1'b1;
    sb.push_back({32'h40F00000, 4'h0});
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk); lat++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || lat != 3) begin errors++; $display("FAIL latency: got %0d cycles (seen=%0d) want 3", lat, got); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (S !== e[35:4]) begin errors++; $display("FAIL latency_S: got %h want %h", S, e[35:4]); end
      checks++; if (flags !== e[3:0]) begin errors++; $display("FAIL latency_flags: got %h want %h", flags, e[3:0]); end
    end
    sb.delete();
  endtask

  task automatic test_vectors();
    logic [31:0] va[12], vb[12], vp[12];
    logic [3:0]  vf[12];
    logic [35:0] e;
    int w;
    va = '{32'h3FC00000, 32'h3F800001, 32'h00000000, 32'h80000000, 32'h7F7FFFFF, 32'h00800000,
           32'h7F800001, 32'h7F800000, 32'h00000001, 32'h3F800001, 32'h3F800003, 32'h3FFFFFFF};
    vb = '{32'h3FC00000, 32'h3F800001, 32'h7F800000, 32'h3F800000, 32'h40000000, 32'h3F000000,
           32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'h3FFFFFFF};
    vp = '{32'h40100000, 32'h3F800002, 32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000,
           32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h3FC00002, 32'h3FC00004, 32'h407FFFFE};
    vf = '{4'h0, 4'h1, 4'h8, 4'h0, 4'h5, 4'h3, 4'h8, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      num1 = va[i]; num2 = vb[i]; in_valid = 1'b1;
      sb.push_back({vp[i], vf[i]});
      @(posedge clk); #1; in_valid = 1'b0;
      w = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && w < 10) begin
        @(negedge clk); w++;
      end
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL vec%0d_timeout: out_valid=%b queued=%0d want a result", i, out_valid, sb.size());
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (S !== e[35:4]) begin errors++; $display("FAIL vec%0d_S: got %h want %h", i, S, e[35:4]); end
        checks++;
        if (flags !== e[3:0]) begin errors++; $display("FAIL vec%0d_flags: got %h want %h", i, flags, e[3:0]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[5], b[5], p[5];
    logic [31:0] held_s;
    logic [3:0]  held_f;
    logic [35:0] e;
    int idx, got, cyc, extra;
    bit stall_prev, saw_low;
    a = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hBF800000, 32'h3F000000};
    b = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40800000, 32'h3F000000};
    p = '{32'h3F800000, 32'h40C00000, 32'h40100000, 32'hC0800000, 32'h3E800000};
    idx = 0; got = 0; cyc = 0; stall_prev = 1'b0; saw_low = 1'b0;
    held_s = '0; held_f = '0;
    while (got < 5 && cyc < 40) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (idx < 5) begin in_valid = 1'b1; num1 = a[idx]; num2 = b[idx]; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_ready === 1'b0) saw_low = 1'b1;
      if (stall_prev) begin
        checks++;
        if (S !== held_s || flags !== held_f || out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_hold c%0d: got S=%h f=%h v=%b want S=%h f=%h v=1", cyc, S, flags, out_valid, held_s, held_f);
        end
      end
      if (in_valid && in_ready === 1'b1) begin sb.push_back({p[idx], 4'h0}); idx++; end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_unexpected: got S=%h want no result", S); end
        else begin
          e = sb.pop_front();
          if (S !== e[35:4] || flags !== e[3:0]) begin
            errors++; $display("FAIL b2b_res%0d: got %h/%h want %h/%h", got, S, flags, e[35:4], e[3:0]);
          end
        end
        got++;
      end
      stall_prev = (out_valid === 1'b1) && !out_ready;
      held_s = S; held_f = flags;
      cyc++;
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (5) begin @(negedge clk); if (out_valid !== 1'b0) extra++; end
    checks++; if (got != 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", got); end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_duplicate: got %0d extra want 0", extra); end
    checks++; if (!saw_low) begin errors++; $display("FAIL b2b_in_ready_low: got never low want low while stalled"); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d queued want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_in_flight();
    int bad;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; num1 = 32'h40400000; num2 = 32'h40200000;
    @(posedge clk); #1;
    num1 = 32'h3FC00000; num2 = 32'h3FC00000;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (8) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_flight_valid: got %0d valid cycles want 0", bad); end
    checks++; if (S !== 32'h0) begin errors++; $display("FAIL rst_flight_S: got %h want 00000000", S); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rst_flight_flags: got %h want 0", flags); end
  endtask

  task automatic test_fp16();
    logic [15:0] a[2], b[2], p[2];
    logic [3:0]  f[2];
    logic [19:0] e;
    int w;
    a = '{16'h3E00, 16'h7BFF};
    b = '{16'h4000, 16'h4000};
    p = '{16'h4200, 16'h7C00};
    f = '{4'h0, 4'h5};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      h_num1 = a[i]; h_num2 = b[i]; h_in_valid = 1'b1;
      sb16.push_back({p[i], f[i]});
      @(posedge clk); #1; h_in_valid = 1'b0;
      w = 0;
      @(negedge clk);
      while (h_out_valid !== 1'b1 && w < 10) begin @(negedge clk); w++; end
      checks++;
      if (h_out_valid !== 1'b1 || sb16.size() == 0) begin
        errors++; $display("FAIL fp16_%0d_timeout: out_valid=%b want 1", i, h_out_valid);
        sb16.delete();
      end else begin
        e = sb16.pop_front();
        if (h_S !== e[19:4]) begin errors++; $display("FAIL fp16_%0d_S: got %h want %h", i, h_S, e[19:4]); end
        checks++;
        if (h_flags !== e[3:0]) begin errors++; $display("FAIL fp16_%0d_flags: got %h want %h", i, h_flags, e[3:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_in_flight();
    test_fp16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
